fetch_op_queue: RTL and testbench
=================================

FETCH_OP_QUEUE -- requirements
Module: fetch_op_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; low SHALL freeze all state.
REQ-006 push_valid  input  1  decoded instruction offered by the fetch/decode stage.
REQ-007 push_pc  input  32  address of the offered instruction.
REQ-008 push_op  input  5  decoded operation code.
REQ-009 push_branch, push_ls, push_use_imm, push_jalr  input  1 each  decoded class flags.
REQ-010 push_rd, push_rs1, push_rs2  input  5 each  register indices.
REQ-011 push_imm  input  32  decoded immediate.
REQ-012 push_pred_taken  input  1  branch-predictor direction for this instruction.
REQ-013 flush  input  1  misprediction/redirect; discards all entries.
REQ-014 foq_full  output  1  queue holds DEPTH entries.
REQ-015 out_valid  output  1  head entry present.
REQ-016 out_pc, out_op, out_branch, out_ls, out_use_imm, out_jalr, out_rd, out_rs1, out_rs2, out_imm, out_pred_taken  output  widths as push_*  head entry fields.
REQ-017 issue_ready  input  1  issue stage accepts the head entry this cycle.
REQ-018 count  output  AW+1  current occupancy.

Function
REQ-019 Storage SHALL be a circular buffer with head pointer, tail pointer, and occupancy counter, each AW or AW+1 bits; pointers SHALL wrap modulo DEPTH.
REQ-020 foq_full SHALL equal (count == DEPTH); out_valid SHALL equal (count != 0); both are combinational from registered count.
REQ-021 Push acceptance: push_valid && !foq_full && rdy_in && !flush; accepted fields are written at tail, and tail increments.
REQ-022 A push offered while foq_full SHALL be dropped, with no state change from the push, even if a pop occurs in the same cycle.
REQ-023 Pop: out_valid && issue_ready && rdy_in && !flush; head increments.
REQ-024 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 out_* SHALL present storage[head] combinationally, with zero-cycle fall-through latency from registered state; an entry pushed at edge N SHALL be visible at out_* after edge N (minimum one cycle push-to-out).
REQ-026 out_* SHALL be don't-care when out_valid is 0; the bench SHALL NOT check them then.
REQ-027 flush SHALL take priority over push and pop: on the next edge head=tail=0, count=0; storage contents need not be cleared.
REQ-028 When rdy_in is low, pointers, count, and storage SHALL hold regardless of push_valid, issue_ready, or flush.
REQ-029 Entry order SHALL be strict FIFO; no entry is duplicated, reordered, or lost except by flush or dropped push.

Reset
REQ-030 On rst_in high at a rising edge: head=0, tail=0, count=0, giving foq_full=0 and out_valid=0; rst_in SHALL override rdy_in, flush, push, and pop.
REQ-031 Reset asserted mid-operation SHALL discard all entries within that one edge; the first post-reset push SHALL appear at out_* with out_valid=1 one cycle later.

Verification (DEPTH=4)
REQ-032 Reset, then push pc=0x0, 0x4, 0x8, 0xC on consecutive cycles with issue_ready=0 -> count=4, foq_full=1, out_pc=0x0.
REQ-033 Full queue, push pc=0x10 with issue_ready=1 -> pc=0x10 dropped; count=3; out_pc=0x4; popping the rest yields 0x8, 0xC, then out_valid=0.
REQ-034 count=2, simultaneous push pc=0x20 and pop -> count stays 2; order is preserved; pointers wrap past index 3 to 0 without error over 10 cycles of continuous push and pop.
REQ-035 count=3, flush=1 with push_valid=1 and issue_ready=1 -> next cycle count=0, out_valid=0, foq_full=0; the push is not stored.
REQ-036 count=2, rdy_in=0 for 3 cycles with push_valid, issue_ready, and flush toggling -> count=2 and out_pc unchanged throughout; after that, normal operation resumes.
REQ-037 count=4, rst_in=1 for one cycle -> count=0; then push pc=0x40 -> out_valid=1, out_pc=0x40, count=1.

Source files
------------

// File: rtl/fetch_op_queue_if.sv
// Fetch/decode-to-issue handshake bundle for the fetch op queue.
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface fetch_op_queue_if #(
  parameter int AW = 3
);
  logic          push_valid;
  logic [31:0]   push_pc;
  logic [4:0]    push_op;
  logic          push_branch;
  logic          push_ls;
  logic          push_use_imm;
  logic          push_jalr;
  logic [4:0]    push_rd;
  logic [4:0]    push_rs1;
  logic [4:0]    push_rs2;
  logic [31:0]   push_imm;
  logic          push_pred_taken;
  logic          flush;
  logic          foq_full;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [4:0]    out_op;
  logic          out_branch;
  logic          out_ls;
  logic          out_use_imm;
  logic          out_jalr;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [31:0]   out_imm;
  logic          out_pred_taken;
  logic          issue_ready;
  logic [AW:0]   count;

  modport slave (
    input  push_valid, push_pc, push_op, push_branch, push_ls, push_use_imm,
           push_jalr, push_rd, push_rs1, push_rs2, push_imm, push_pred_taken,
           flush, issue_ready,
    output foq_full, out_valid, out_pc, out_op, out_branch, out_ls, out_use_imm,
           out_jalr, out_rd, out_rs1, out_rs2, out_imm, out_pred_taken, count
  );

  modport master (
    output push_valid, push_pc, push_op, push_branch, push_ls, push_use_imm,
           push_jalr, push_rd, push_rs1, push_rs2, push_imm, push_pred_taken,
           flush, issue_ready,
    input  foq_full, out_valid, out_pc, out_op, out_branch, out_ls, out_use_imm,
           out_jalr, out_rd, out_rs1, out_rs2, out_imm, out_pred_taken, count
  );
endinterface

// File: rtl/fetch_op_queue.sv
// Circular FIFO of decoded instructions between fetch/decode and issue.
// Head entry falls through combinationally; flush empties the queue in one edge.
module fetch_op_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  fetch_op_queue_if.slave foq
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic        jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        pred_taken;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          push_acc;
  logic          pop_acc;
  entry_t        push_entry;
  entry_t        head_entry;

  assign foq.foq_full  = (count_q == (AW+1)'(DEPTH));
  assign foq.out_valid = (count_q != '0);
  assign foq.count     = count_q;

  // A push offered while full is dropped even if a pop frees a slot this cycle.
  assign push_acc = foq.push_valid && !foq.foq_full && rdy_in && !foq.flush;
  assign pop_acc  = foq.out_valid && foq.issue_ready && rdy_in && !foq.flush;

  assign push_entry = '{
    pc:         foq.push_pc,
    op:         foq.push_op,
    branch:     foq.push_branch,
    ls:         foq.push_ls,
    use_imm:    foq.push_use_imm,
    jalr:       foq.push_jalr,
    rd:         foq.push_rd,
    rs1:        foq.push_rs1,
    rs2:        foq.push_rs2,
    imm:        foq.push_imm,
    pred_taken: foq.push_pred_taken
  };

  assign head_entry         = mem_q[head_q];
  assign foq.out_pc         = head_entry.pc;
  assign foq.out_op         = head_entry.op;
  assign foq.out_branch     = head_entry.branch;
  assign foq.out_ls         = head_entry.ls;
  assign foq.out_use_imm    = head_entry.use_imm;
  assign foq.out_jalr       = head_entry.jalr;
  assign foq.out_rd         = head_entry.rd;
  assign foq.out_rs1        = head_entry.rs1;
  assign foq.out_rs2        = head_entry.rs2;
  assign foq.out_imm        = head_entry.imm;
  assign foq.out_pred_taken = head_entry.pred_taken;

  // Next pointer/occupancy: hold when disabled, clear on flush, else advance.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (foq.flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_acc) tail_d = tail_q + AW'(1);
        if (pop_acc)  head_d = head_q + AW'(1);
        unique case ({push_acc, pop_acc})
          2'b10:   count_d = count_q + (AW+1)'(1);
          2'b01:   count_d = count_q - (AW+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail on an accepted push; contents never cleared.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_acc) mem_q[tail_q] <= push_entry;
  end

endmodule

// File: tb/tb_fetch_op_queue.sv
// Randomized and directed bench for fetch_op_queue against a queue-based model.
module tb_fetch_op_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [24:0] misc;
  } ref_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  ref_entry_t model_q[$];

  fetch_op_queue_if #(.AW(AW)) bus ();

  fetch_op_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .foq    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] push_misc();
    return {bus.push_op, bus.push_branch, bus.push_ls, bus.push_use_imm, bus.push_jalr,
            bus.push_rd, bus.push_rs1, bus.push_rs2, bus.push_pred_taken};
  endfunction

  function automatic logic [24:0] out_misc();
    return {bus.out_op, bus.out_branch, bus.out_ls, bus.out_use_imm, bus.out_jalr,
            bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_pred_taken};
  endfunction

  task automatic set_push(input logic v, input logic [31:0] pc);
    bus.push_valid      = v;
    bus.push_pc         = pc;
    bus.push_op         = 5'($urandom);
    bus.push_branch     = 1'($urandom);
    bus.push_ls         = 1'($urandom);
    bus.push_use_imm    = 1'($urandom);
    bus.push_jalr       = 1'($urandom);
    bus.push_rd         = 5'($urandom);
    bus.push_rs1        = 5'($urandom);
    bus.push_rs2        = 5'($urandom);
    bus.push_imm        = $urandom;
    bus.push_pred_taken = 1'($urandom);
  endtask

  task automatic compare_all();
    check_eq("count", 64'(bus.count), 64'(model_q.size()));
    check_eq("foq_full", 64'(bus.foq_full), 64'(model_q.size() == DEPTH));
    check_eq("out_valid", 64'(bus.out_valid), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check_eq("out_pc", 64'(bus.out_pc), 64'(model_q[0].pc));
      check_eq("out_imm", 64'(bus.out_imm), 64'(model_q[0].imm));
      check_eq("out_misc", 64'(out_misc()), 64'(model_q[0].misc));
    end
  endtask

  // One clock edge: advance the model from the inputs in force, then compare.
  task automatic tick();
    ref_entry_t e;
    bit do_pop;
    bit do_push;
    @(posedge clk);
    e.pc   = bus.push_pc;
    e.imm  = bus.push_imm;
    e.misc = push_misc();
    if (rst) begin
      model_q.delete();
    end else if (rdy) begin
      if (bus.flush) begin
        model_q.delete();
      end else begin
        do_pop  = (model_q.size() != 0) && bus.issue_ready;
        do_push = bus.push_valid && (model_q.size() < DEPTH);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b0;
    set_push(1'b1, 32'hdead_beef);
    tick();
    tick();
    rst = 1'b0;
    set_push(1'b0, 32'h0);
    tick();

    // Fill to full with issue stalled.
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'(i * 4));
      tick();
    end
    check_eq("fill_count", 64'(bus.count), 64'd4);
    check_eq("fill_full", 64'(bus.foq_full), 64'd1);
    check_eq("fill_head", 64'(bus.out_pc), 64'h0);

    // Push while full with a pop: push dropped.
    set_push(1'b1, 32'h10);
    bus.issue_ready = 1'b1;
    tick();
    check_eq("drop_count", 64'(bus.count), 64'd3);
    check_eq("drop_head", 64'(bus.out_pc), 64'h4);
    set_push(1'b0, 32'h0);
    tick();
    check_eq("drain_8", 64'(bus.out_pc), 64'h8);
    tick();
    check_eq("drain_c", 64'(bus.out_pc), 64'hc);
    tick();
    check_eq("drain_empty", 64'(bus.out_valid), 64'd0);

    // Two entries, then steady push+pop with pointer wraparound.
    bus.issue_ready = 1'b0;
    set_push(1'b1, 32'h100); tick();
    set_push(1'b1, 32'h104); tick();
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_push(1'b1, 32'h20 + 32'(i * 4));
      tick();
    end
    check_eq("stream_count", 64'(bus.count), 64'd2);
    check_eq("stream_head", 64'(bus.out_pc), 64'h40);

    // Flush with push and pop offered.
    bus.issue_ready = 1'b0;
    set_push(1'b1, 32'h200); tick();
    bus.flush = 1'b1;
    bus.issue_ready = 1'b1;
    set_push(1'b1, 32'h204);
    tick();
    bus.flush = 1'b0;
    check_eq("flush_count", 64'(bus.count), 64'd0);
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_full", 64'(bus.foq_full), 64'd0);

    // Global enable low freezes everything.
    bus.issue_ready = 1'b0;
    set_push(1'b1, 32'h300); tick();
    set_push(1'b1, 32'h304); tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(1'($urandom), 32'h3f0 + 32'(i));
      bus.issue_ready = 1'($urandom);
      bus.flush       = 1'(i & 1);
      tick();
      check_eq("frozen_count", 64'(bus.count), 64'd2);
      check_eq("frozen_head", 64'(bus.out_pc), 64'h300);
    end
    rdy = 1'b1;
    bus.flush = 1'b0;
    bus.issue_ready = 1'b1;
    set_push(1'b0, 32'h0);
    tick();
    check_eq("resume_head", 64'(bus.out_pc), 64'h304);

    // Reset from full, then first push falls through.
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h500 + 32'(i * 4));
      tick();
    end
    check_eq("prerst_count", 64'(bus.count), 64'd4);
    set_push(1'b1, 32'h600);
    bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_count", 64'(bus.count), 64'd0);
    set_push(1'b1, 32'h40);
    tick();
    check_eq("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check_eq("post_rst_pc", 64'(bus.out_pc), 64'h40);
    check_eq("post_rst_count", 64'(bus.count), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_push(1'($urandom_range(0, 99) < 60), $urandom);
      bus.issue_ready = 1'($urandom_range(0, 99) < 50);
      bus.flush       = 1'($urandom_range(0, 99) < 4);
      rdy             = 1'($urandom_range(0, 99) < 85);
      rst             = 1'($urandom_range(0, 199) < 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
